// File: rtl/decode_stage_if.sv
// Decode-stage bundle: F/D inputs, writeback port and the decoded D/E outputs.
// slave is the decode stage itself; master is whoever drives and observes it.
interface decode_stage_if;
  logic [31:0] instr_d;
  logic [31:0] pc_d_in;
  logic [31:0] pcplus4_d_in;
  logic        RegWrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;

  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic [31:0] ext_imm_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        RegWrite_d;
  logic        MemWrite_d;
  logic        Jump_d;
  logic        Branch_d;
  logic        ALUSrc_d;
  logic [1:0]  ResultSrc_d;
  logic [3:0]  ALUControl_d;
  logic        illegal_d;
  logic        illegal_seen;
  logic [31:0] illegal_pc;

  modport slave (
    input  instr_d, pc_d_in, pcplus4_d_in, RegWrite_w, rd_w, result_w,
    output rd1_d, rd2_d, rs1_d, rs2_d, rd_d, ext_imm_d, pc_d, pcplus4_d,
           RegWrite_d, MemWrite_d, Jump_d, Branch_d, ALUSrc_d, ResultSrc_d,
           ALUControl_d, illegal_d, illegal_seen, illegal_pc
  );

  modport master (
    output instr_d, pc_d_in, pcplus4_d_in, RegWrite_w, rd_w, result_w,
    input  rd1_d, rd2_d, rs1_d, rs2_d, rd_d, ext_imm_d, pc_d, pcplus4_d,
           RegWrite_d, MemWrite_d, Jump_d, Branch_d, ALUSrc_d, ResultSrc_d,
           ALUControl_d, illegal_d, illegal_seen, illegal_pc
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, control decode,
// immediate generation and a sticky record of the first illegal instruction.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

  logic [XLEN-1:0] regs [0:NREGS-1];
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2;
  logic            use_rs1, use_rs2, use_rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign instr  = bus.instr_d;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};

  // funct7[5] means SUB only on register-register ops; on shifts it always means SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic is_r);
    case (f3)
      3'b000:  alu_op = (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    bus.RegWrite_d   = 1'b0;
    bus.MemWrite_d   = 1'b0;
    bus.Jump_d       = 1'b0;
    bus.Branch_d     = 1'b0;
    bus.ALUSrc_d     = 1'b0;
    bus.ResultSrc_d  = 2'b00;
    bus.ALUControl_d = ALU_ADD;
    bus.ext_imm_d    = '0;
    bus.illegal_d    = 1'b0;
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    use_rd           = 1'b0;
    if (instr != 32'h0) begin
      case (opcode)
        OP_R: begin
          bus.RegWrite_d   = 1'b1;
          bus.ALUControl_d = alu_op(funct3, instr[30], 1'b1);
          {use_rs1, use_rs2, use_rd} = 3'b111;
        end
        OP_I: begin
          bus.RegWrite_d   = 1'b1;
          bus.ALUSrc_d     = 1'b1;
          bus.ALUControl_d = alu_op(funct3, instr[30], 1'b0);
          bus.ext_imm_d    = imm_i;
          {use_rs1, use_rd} = 2'b11;
        end
        OP_LOAD: begin
          if (funct3 == 3'b010) begin
            bus.RegWrite_d  = 1'b1;
            bus.ResultSrc_d = 2'b01;
            bus.ALUSrc_d    = 1'b1;
            bus.ext_imm_d   = imm_i;
            {use_rs1, use_rd} = 2'b11;
          end else bus.illegal_d = 1'b1;
        end
        OP_STORE: begin
          if (funct3 == 3'b010) begin
            bus.MemWrite_d = 1'b1;
            bus.ALUSrc_d   = 1'b1;
            bus.ext_imm_d  = imm_s;
            {use_rs1, use_rs2} = 2'b11;
          end else bus.illegal_d = 1'b1;
        end
        OP_BRANCH: begin
          if (funct3 != 3'b010 && funct3 != 3'b011) begin
            bus.Branch_d     = 1'b1;
            bus.ALUControl_d = {1'b0, funct3};
            bus.ext_imm_d    = imm_b;
            {use_rs1, use_rs2} = 2'b11;
          end else bus.illegal_d = 1'b1;
        end
        OP_JAL: begin
          bus.Jump_d      = 1'b1;
          bus.RegWrite_d  = 1'b1;
          bus.ResultSrc_d = 2'b10;
          bus.ext_imm_d   = imm_j;
          use_rd          = 1'b1;
        end
        OP_JALR: begin
          if (funct3 == 3'b000) begin
            bus.Jump_d      = 1'b1;
            bus.RegWrite_d  = 1'b1;
            bus.ResultSrc_d = 2'b10;
            bus.ALUSrc_d    = 1'b1;
            bus.ext_imm_d   = imm_i;
            {use_rs1, use_rd} = 2'b11;
          end else bus.illegal_d = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          bus.RegWrite_d   = 1'b1;
          bus.ALUSrc_d     = 1'b1;
          bus.ALUControl_d = ALU_PASSB;
          bus.ext_imm_d    = (opcode == OP_AUIPC) ? bus.pc_d_in + imm_u : imm_u;
          use_rd           = 1'b1;
        end
        default: bus.illegal_d = 1'b1;
      endcase
    end
  end

  assign rs1        = use_rs1 ? instr[19:15] : 5'd0;
  assign rs2        = use_rs2 ? instr[24:20] : 5'd0;
  assign bus.rs1_d  = rs1;
  assign bus.rs2_d  = rs2;
  assign bus.rd_d   = use_rd ? instr[11:7] : 5'd0;
  assign bus.pc_d      = bus.pc_d_in;
  assign bus.pcplus4_d = bus.pcplus4_d_in;

  // Write-through: a writeback to the register being read is seen in the same cycle.
  assign bus.rd1_d = (rs1 == 5'd0) ? '0 :
                     (bus.RegWrite_w && bus.rd_w == rs1) ? bus.result_w : regs[rs1];
  assign bus.rd2_d = (rs2 == 5'd0) ? '0 :
                     (bus.RegWrite_w && bus.rd_w == rs2) ? bus.result_w : regs[rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.RegWrite_w && bus.rd_w != 5'd0) begin
      regs[bus.rd_w] <= bus.result_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.illegal_seen <= 1'b0;
      bus.illegal_pc   <= '0;
    end else if (bus.illegal_d && !bus.illegal_seen) begin
      bus.illegal_seen <= 1'b1;
      bus.illegal_pc   <= bus.pc_d_in;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected field values into a
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  localparam int F_RD1 = 0, F_RD2 = 1, F_IMM = 2, F_ALUSRC = 3, F_ALUCTL = 4,
                 F_REGW = 5, F_BRANCH = 6, F_RDD = 7, F_ILL = 8, F_SEEN = 9,
                 F_ILLPC = 10, F_RESSRC = 11, F_MEMW = 12, F_JUMP = 13,
                 F_RS1 = 14, F_RS2 = 15, F_PC = 16, F_PC4 = 17;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  function automatic logic [31:0] field(input int sel);
    case (sel)
      F_RD1:    field = bus.rd1_d;
      F_RD2:    field = bus.rd2_d;
      F_IMM:    field = bus.ext_imm_d;
      F_ALUSRC: field = {31'b0, bus.ALUSrc_d};
      F_ALUCTL: field = {28'b0, bus.ALUControl_d};
      F_REGW:   field = {31'b0, bus.RegWrite_d};
      F_BRANCH: field = {31'b0, bus.Branch_d};
      F_RDD:    field = {27'b0, bus.rd_d};
      F_ILL:    field = {31'b0, bus.illegal_d};
      F_SEEN:   field = {31'b0, bus.illegal_seen};
      F_ILLPC:  field = bus.illegal_pc;
      F_RESSRC: field = {30'b0, bus.ResultSrc_d};
      F_MEMW:   field = {31'b0, bus.MemWrite_d};
      F_JUMP:   field = {31'b0, bus.Jump_d};
      F_RS1:    field = {27'b0, bus.rs1_d};
      F_RS2:    field = {27'b0, bus.rs2_d};
      F_PC:     field = bus.pc_d;
      default:  field = bus.pcplus4_d;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      if (field(c.sel) !== c.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, field(c.sel), c.val);
      end
    end
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic ex(input string n, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = n; c.sel = sel; c.val = v;
    q.push_back(c);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic we, input logic [4:0] rdw, input logic [31:0] res);
    @(posedge clk);
    #1;
    bus.instr_d      = instr;
    bus.pc_d_in      = pc;
    bus.pcplus4_d_in = pc + 32'd4;
    bus.RegWrite_w   = we;
    bus.rd_w         = rdw;
    bus.result_w     = res;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    r_type = {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  initial begin
    bus.instr_d = '0; bus.pc_d_in = '0; bus.pcplus4_d_in = 32'd4;
    bus.RegWrite_w = 1'b0; bus.rd_w = '0; bus.result_w = '0;

    ex("reset_seen", F_SEEN, 0);
    ex("reset_illpc", F_ILLPC, 0);
    ex("bubble_regw", F_REGW, 0);
    ex("bubble_ill", F_ILL, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = i[4:0];
      drive(r_type(7'b0, r, r, 3'b000, 5'd1), 32'h0, 1'b0, 5'd0, 32'h0);
      ex("reset_read_rs1", F_RD1, 0);
      ex("reset_read_rs2", F_RD2, 0);
    end

    drive(r_type(7'b0, 5'd0, 5'd0, 3'b000, 5'd1), 32'h0, 1'b1, 5'd0, 32'h0000DEAD);
    ex("x0_write_same_cycle", F_RD1, 0);
    drive(r_type(7'b0, 5'd0, 5'd0, 3'b000, 5'd1), 32'h0, 1'b0, 5'd0, 32'h0);
    ex("x0_write_next_cycle", F_RD1, 0);

    drive(r_type(7'b0, 5'd5, 5'd5, 3'b000, 5'd6), 32'h0, 1'b1, 5'd5, 32'h00001234);
    #1;
    checks++;
    if (bus.rd1_d !== 32'h00001234) begin
      failures++;
      $display("FAIL direct_bypass_rd1: got 0x%08h expected 0x00001234", bus.rd1_d);
    end
    ex("bypass_rd1", F_RD1, 32'h1234);
    ex("bypass_rd2", F_RD2, 32'h1234);
    ex("add_regw", F_REGW, 1);
    ex("add_alusrc", F_ALUSRC, 0);
    ex("add_aluctl", F_ALUCTL, 4'b0000);
    ex("add_rd", F_RDD, 6);
    drive(r_type(7'b0, 5'd5, 5'd5, 3'b000, 5'd6), 32'h0, 1'b0, 5'd0, 32'h0);
    ex("stored_x5", F_RD1, 32'h1234);

    drive(32'h0, 32'h0, 1'b1, 5'd7, 32'hCAFEF00D);
    ex("bubble_rd", F_RDD, 0);
    ex("bubble_rs1", F_RS1, 0);
    drive(r_type(7'b0100000, 5'd5, 5'd7, 3'b000, 5'd8), 32'h0, 1'b0, 5'd0, 32'h0);
    ex("sub_aluctl", F_ALUCTL, 4'b0001);
    ex("sub_rd1", F_RD1, 32'hCAFEF00D);
    ex("sub_rd2", F_RD2, 32'h1234);

    drive(32'hFFF00093, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.ext_imm_d !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL direct_addi_imm: got 0x%08h expected 0xFFFFFFFF", bus.ext_imm_d);
    end
    ex("addi_imm", F_IMM, 32'hFFFFFFFF);
    ex("addi_alusrc", F_ALUSRC, 1);
    ex("addi_aluctl", F_ALUCTL, 4'b0000);
    ex("addi_rd", F_RDD, 1);
    ex("addi_rs2_unused", F_RS2, 0);

    drive({20'h00001, 5'd2, 7'b0010111}, 32'h100, 1'b0, 5'd0, 32'h0);
    ex("auipc_imm", F_IMM, 32'h1100);
    ex("auipc_aluctl", F_ALUCTL, 4'b1010);
    ex("auipc_regw", F_REGW, 1);
    ex("auipc_pc", F_PC, 32'h100);
    ex("auipc_pc4", F_PC4, 32'h104);

    drive({20'hFFFFF, 5'd3, 7'b0110111}, 32'h100, 1'b0, 5'd0, 32'h0);
    ex("lui_imm", F_IMM, 32'hFFFFF000);
    ex("lui_aluctl", F_ALUCTL, 4'b1010);

    drive(32'hFE209EE3, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.Branch_d !== 1'b1) begin
      failures++;
      $display("FAIL direct_bne_branch: got %b expected 1", bus.Branch_d);
    end
    ex("bne_branch", F_BRANCH, 1);
    ex("bne_aluctl", F_ALUCTL, 4'b0001);
    ex("bne_imm", F_IMM, 32'hFFFFFFFC);
    ex("bne_rd", F_RDD, 0);
    ex("bne_regw", F_REGW, 0);
    ex("bne_rs2", F_RS2, 2);

    drive(32'h008000EF, 32'h0, 1'b0, 5'd0, 32'h0);
    ex("jal_jump", F_JUMP, 1);
    ex("jal_ressrc", F_RESSRC, 2);
    ex("jal_imm", F_IMM, 8);

    drive({12'd12, 5'd2, 3'b010, 5'd4, 7'b0000011}, 32'h0, 1'b0, 5'd0, 32'h0);
    ex("lw_ressrc", F_RESSRC, 1);
    ex("lw_imm", F_IMM, 12);
    ex("lw_rs1", F_RS1, 2);

    drive({7'd0, 5'd5, 5'd2, 3'b010, 5'd8, 7'b0100011}, 32'h0, 1'b0, 5'd0, 32'h0);
    ex("sw_memw", F_MEMW, 1);
    ex("sw_rd", F_RDD, 0);
    ex("sw_imm", F_IMM, 8);
    ex("sw_regw", F_REGW, 0);

    drive({7'b0100000, 5'd3, 5'd9, 3'b101, 5'd9, 7'b0010011}, 32'h0, 1'b0, 5'd0, 32'h0);
    ex("srai_aluctl", F_ALUCTL, 4'b1001);

    drive(32'hFFFFFFFF, 32'h40, 1'b0, 5'd0, 32'h0);
    ex("illegal_flag", F_ILL, 1);
    ex("illegal_regw", F_REGW, 0);
    ex("illegal_not_yet_seen", F_SEEN, 0);
    drive(32'h0, 32'h44, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.illegal_pc !== 32'h00000040) begin
      failures++;
      $display("FAIL direct_sticky_pc: got 0x%08h expected 0x00000040", bus.illegal_pc);
    end
    ex("sticky_seen", F_SEEN, 1);
    ex("sticky_pc", F_ILLPC, 32'h40);
    ex("bubble_after_ill", F_ILL, 0);
    drive(32'h0000000F, 32'h80, 1'b0, 5'd0, 32'h0);
    ex("fence_illegal", F_ILL, 1);
    drive({12'd0, 5'd2, 3'b000, 5'd4, 7'b0000011}, 32'h84, 1'b0, 5'd0, 32'h0);
    ex("lb_illegal", F_ILL, 1);
    ex("sticky_pc_kept", F_ILLPC, 32'h40);
    drive(32'h0, 32'h88, 1'b0, 5'd0, 32'h0);
    ex("sticky_pc_still", F_ILLPC, 32'h40);

    @(posedge clk); #1;
    rst = 1'b1;
    bus.instr_d = r_type(7'b0, 5'd7, 5'd5, 3'b000, 5'd1);
    ex("rst_clears_seen", F_SEEN, 0);
    ex("rst_clears_pc", F_ILLPC, 0);
    ex("rst_clears_x5", F_RD1, 0);
    ex("rst_clears_x7", F_RD2, 0);
    @(posedge clk); #1 rst = 1'b0;
    ex("post_rst_x5", F_RD1, 0);
    ex("post_rst_regw_comb", F_REGW, 1);

    @(posedge clk); #1;
    done = 1'b1;
  end
endmodule
